// File: rtl/spi_master_cmd.sv
// rtl/spi_master_cmd.sv - SPI mode-0 command master with full-duplex response capture
// Sends {code, data, 8'h00} MSB first and returns the MISO word of each frame.
module spi_master_cmd #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    bit_q;
  logic [31:0]   frame_q;
  logic [31:0]   rx_q;
  logic          miso_s1_q;
  logic          miso_s2_q;
  logic          cs_n_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic          busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      rx_q        <= '0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      miso_s1_q   <= miso;
      miso_s2_q   <= miso_s1_q;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            frame_q     <= {cmd_code, cmd_data, 8'h00};
            mosi_q      <= cmd_code[7];
            cs_n_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            state_q     <= SETUP;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_q  <= {rx_q[30:0], miso_s2_q};
              bit_q <= bit_q + 1'b1;
            end else if (bit_q == 6'd32) begin
              state_q <= HOLD;
            end else begin
              // bit_q rising edges are done, so bit 31-bit_q is next
              mosi_q <= frame_q[5'd31 - bit_q[4:0]];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q       <= '0;
            cs_n_q      <= 1'b1;
            rsp_data_q  <= rx_q;
            rsp_valid_q <= 1'b1;
            state_q     <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == IDLE_LAST) begin
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_master_cmd.sv
// tb/tb_spi_master_cmd.sv - self-checking bench for spi_master_cmd
// Two instances: CLK_DIV=4 (main) and CLK_DIV=2 (minimum divider).
module tb_spi_master_cmd;

  localparam int S  = 4;
  localparam int H  = 4;
  localparam int I  = 8;
  localparam int D0 = 4;
  localparam int D1 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd_valid = 2'b00;
  logic [7:0]  cmd_code [2];
  logic [15:0] cmd_data [2];
  logic [1:0]  miso = 2'b00;
  wire  [1:0]  cmd_ready, rsp_valid, busy, sclk, mosi, cs_n;
  wire  [31:0] rsp_data0, rsp_data1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_cmd #(.CLK_DIV(D0), .CS_SETUP(S), .CS_HOLD(H), .CS_IDLE(I)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_code(cmd_code[0]), .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]),
    .rsp_data(rsp_data0), .busy(busy[0]), .sclk(sclk[0]), .mosi(mosi[0]),
    .miso(miso[0]), .cs_n(cs_n[0])
  );

  spi_master_cmd #(.CLK_DIV(D1), .CS_SETUP(S), .CS_HOLD(H), .CS_IDLE(I)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_code(cmd_code[1]), .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]),
    .rsp_data(rsp_data1), .busy(busy[1]), .sclk(sclk[1]), .mosi(mosi[1]),
    .miso(miso[1]), .cs_n(cs_n[1])
  );

  // Bus monitor and mode-0 slave model, one lane per instance
  int          rises [2]       = '{default: 0};
  int          cs_low [2]      = '{default: 0};
  int          last_cs_low [2] = '{default: 0};
  int          cs_high [2]     = '{default: 0};
  int          last_gap [2]    = '{default: 0};
  int          frames [2]      = '{default: 0};
  int          rsps [2]        = '{default: 0};
  int          dbl [2]         = '{default: 0};
  int          rdy_busy [2]    = '{default: 0};
  int          hcnt [2]        = '{default: 0};
  int          hmin [2]        = '{default: 0};
  int          hmax [2]        = '{default: 0};
  logic        first [2]       = '{default: 1'b0};
  logic [31:0] cap [2]         = '{default: 32'h0};
  logic [31:0] sh [2]          = '{default: 32'h0};
  logic [31:0] slv_word [2]    = '{default: 32'h0};
  logic        sclk_p [2]      = '{default: 1'b0};
  logic        cs_p [2]        = '{default: 1'b1};
  logic        rv_p [2]        = '{default: 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!cs_n[d] && cs_p[d]) begin
        frames[d]   <= frames[d] + 1;
        rises[d]    <= 0;
        cap[d]      <= 32'h0;
        cs_low[d]   <= 1;
        last_gap[d] <= cs_high[d];
        sh[d]       <= slv_word[d] << 1;
        miso[d]     <= slv_word[d][31];
        first[d]    <= 1'b1;
        hcnt[d]     <= 0;
        hmin[d]     <= 999;
        hmax[d]     <= 0;
      end else if (!cs_n[d]) begin
        cs_low[d] <= cs_low[d] + 1;
        if (sclk[d] != sclk_p[d]) begin
          if (!first[d]) begin
            if (hcnt[d] + 1 < hmin[d]) hmin[d] <= hcnt[d] + 1;
            if (hcnt[d] + 1 > hmax[d]) hmax[d] <= hcnt[d] + 1;
          end
          first[d] <= 1'b0;
          hcnt[d]  <= 0;
          if (sclk[d]) begin
            rises[d] <= rises[d] + 1;
            cap[d]   <= {cap[d][30:0], mosi[d]};
          end else begin
            miso[d] <= sh[d][31];
            sh[d]   <= sh[d] << 1;
          end
        end else begin
          hcnt[d] <= hcnt[d] + 1;
        end
      end
      if (cs_n[d] && !cs_p[d]) begin
        last_cs_low[d] <= cs_low[d];
        cs_high[d]     <= 1;
      end else if (cs_n[d]) begin
        cs_high[d] <= cs_high[d] + 1;
      end
      if (rsp_valid[d]) begin
        rsps[d] <= rsps[d] + 1;
        if (rv_p[d]) dbl[d] <= dbl[d] + 1;
      end
      if (cmd_ready[d] && busy[d]) rdy_busy[d] <= rdy_busy[d] + 1;
      rv_p[d]   <= rsp_valid[d];
      sclk_p[d] <= sclk[d];
      cs_p[d]   <= cs_n[d];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int d, input logic [7:0] code, input logic [15:0] data,
                       output int t_acc);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b1;
    cmd_code[d]  = code;
    cmd_data[d]  = data;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cmd_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    t_acc = cyc;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
    cmd_code[d]  = 8'($urandom);
    cmd_data[d]  = 16'($urandom);
    chk("accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(input int d, output int t_rsp);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        got = 1'b1;
        break;
      end
    end
    t_rsp = cyc;
    chk("rsp_seen", 64'(got), 64'd1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy[d]) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic frame(input int d, input logic [7:0] code, input logic [15:0] data,
                       input logic [31:0] word, input int div, input bit check_rx);
    int t_acc, t_rsp, r0, b0;
    logic [31:0] rd;
    slv_word[d] = word;
    r0 = rsps[d];
    b0 = dbl[d];
    issue(d, code, data, t_acc);
    chk("busy_after_accept", 64'(busy[d]), 64'd1);
    chk("ready_after_accept", 64'(cmd_ready[d]), 64'd0);
    wait_rsp(d, t_rsp);
    chk("latency", 64'(t_rsp - t_acc), 64'(1 + S + 64 * div + H));
    chk("mosi_word", 64'(cap[d]), 64'({code, data, 8'h00}));
    chk("sclk_rises", 64'(rises[d]), 64'd32);
    chk("cs_low_cycles", 64'(last_cs_low[d]), 64'(S + 64 * div + H));
    chk("rsp_pulses", 64'(rsps[d] - r0), 64'd1);
    chk("rsp_single_cycle", 64'(dbl[d] - b0), 64'd0);
    chk("half_min", 64'(hmin[d]), 64'(div));
    chk("half_max", 64'(hmax[d]), 64'(div));
    rd = (d == 0) ? rsp_data0 : rsp_data1;
    if (check_rx) chk("rsp_data", 64'(rd), 64'(word));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_a, t_b, t_r, r0, f0, rb0, nr;
    logic [7:0]  c;
    logic [15:0] dt;
    logic [31:0] w;
    logic        sp;

    cmd_code[0] = 8'h00; cmd_code[1] = 8'h00;
    cmd_data[0] = 16'h0; cmd_data[1] = 16'h0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(cs_n[0]), 64'd1);
    chk("rst_sclk", 64'(sclk[0]), 64'd0);
    chk("rst_mosi", 64'(mosi[0]), 64'd0);
    chk("rst_ready", 64'(cmd_ready[0]), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data0), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_cs_n_1", 64'(cs_n[1]), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", 64'(cmd_ready[0]), 64'd1);
    chk("idle_busy", 64'(busy[0]), 64'd0);

    // Ton = 500 with a random slave word
    frame(0, 8'h10, 16'h01F4, $urandom, D0, 1'b1);

    // Feedback read: rate bytes come back in the response
    frame(0, 8'h20, 16'h0000, 32'h50140A05, D0, 1'b1);
    chk("normal_rate", 64'(rsp_data0[31:24]), 64'h50);

    // Randomized frames, including unsupported codes
    for (int i = 0; i < 4; i++) begin
      c  = 8'($urandom);
      dt = 16'($urandom);
      w  = $urandom;
      frame(0, c, dt, w, D0, 1'b1);
    end

    // Back-to-back with cmd_valid held high
    r0 = rsps[0]; f0 = frames[0]; rb0 = rdy_busy[0];
    slv_word[0] = $urandom;
    issue(0, 8'h01, 16'h0000, t_a);
    cmd_valid[0] = 1'b1;
    cmd_code[0]  = 8'h02;
    cmd_data[0]  = 16'h0000;
    sp = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (cmd_ready[0]) begin
        sp = 1'b1;
        break;
      end
    end
    t_b = cyc;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    chk("b2b_second_accept", 64'(sp), 64'd1);
    chk("b2b_accept_spacing", 64'(t_b - t_a), 64'(1 + S + 64 * D0 + H + I));
    wait_rsp(0, t_r);
    chk("b2b_rsp_pulses", 64'(rsps[0] - r0), 64'd2);
    chk("b2b_frames", 64'(frames[0] - f0), 64'd2);
    chk("b2b_cs_gap_min", 64'(last_gap[0] >= I + 1), 64'd1);
    chk("b2b_ready_while_busy", 64'(rdy_busy[0] - rb0), 64'd0);
    chk("b2b_mosi_word", 64'(cap[0]), 64'h02000000);

    // Short cmd_valid pulse while busy is ignored
    r0 = rsps[0]; f0 = frames[0];
    slv_word[0] = $urandom;
    issue(0, 8'h11, 16'($urandom), t_a);
    repeat (50) @(posedge clk);
    #1;
    cmd_valid[0] = 1'b1;
    cmd_code[0]  = 8'h12;
    @(negedge clk);
    chk("pulse_ready", 64'(cmd_ready[0]), 64'd0);
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    wait_rsp(0, t_r);
    repeat (20) @(posedge clk);
    #1;
    chk("pulse_frames", 64'(frames[0] - f0), 64'd1);
    chk("pulse_rsps", 64'(rsps[0] - r0), 64'd1);
    chk("pulse_idle_busy", 64'(busy[0]), 64'd0);
    chk("pulse_idle_ready", 64'(cmd_ready[0]), 64'd1);

    // Reset at the 10th sclk rising edge
    r0 = rsps[0];
    slv_word[0] = $urandom;
    issue(0, 8'hAA, 16'($urandom), t_a);
    nr = 0;
    sp = sclk[0];
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (sclk[0] && !sp) nr++;
      sp = sclk[0];
      if (nr == 10) break;
    end
    chk("rst_mid_reached", 64'(nr), 64'd10);
    rst = 1'b1;
    #1;
    chk("rst_mid_cs_n", 64'(cs_n[0]), 64'd1);
    chk("rst_mid_sclk", 64'(sclk[0]), 64'd0);
    chk("rst_mid_busy", 64'(busy[0]), 64'd0);
    chk("rst_mid_ready", 64'(cmd_ready[0]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("rst_mid_no_rsp", 64'(rsps[0] - r0), 64'd0);
    frame(0, 8'h12, 16'($urandom), $urandom, D0, 1'b1);

    // Minimum divider: sclk period of 4 clk cycles
    frame(1, 8'h13, 16'h2001, $urandom, D1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
